// File: rtl/safe_startup_sequencer.sv
// rtl/safe_startup_sequencer.sv - ordered multi-stage plant startup interlock with fault latching
module safe_startup_sequencer #(
  parameter int N_STAGES       = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SETTLE_CYCLES  = 16,
  localparam int IDX_W         = (N_STAGES > 2) ? $clog2(N_STAGES) : 1
) (
  input  logic                System_Clock,
  input  logic                System_Reset,
  input  logic                Start_Request,
  input  logic                Stop_Request,
  input  logic [N_STAGES-1:0] Stage_Confirm,
  input  logic                Fault_Clear,
  output logic [N_STAGES-1:0] Stage_Enable,
  output logic                Master_Start,
  output logic                Sequence_Busy,
  output logic                Fault,
  output logic [IDX_W-1:0]    Fault_Stage,
  output logic [1:0]          Fault_Code
);

  localparam int MAX_CYC = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(N_STAGES - 1);

  typedef enum logic [2:0] {S_IDLE, S_STEP, S_SETTLE, S_RUN, S_STOP, S_FAULT} state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    k, k_n, fstage_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [1:0]          code_n;
  logic [N_STAGES-1:0] en_n;
  logic                ms_n, busy_n, fault_n;
  logic                go, conf_k;
  logic                lost_any, early_any, low_any, high_any;
  logic [IDX_W-1:0]    lost_idx, early_idx, low_idx, high_idx;
  logic                f_hit;
  logic [1:0]          f_code;
  logic [IDX_W-1:0]    f_idx;

  assign go     = Start_Request && !Stop_Request;
  assign conf_k = Stage_Confirm[k];

  // Descending scan so the last hit recorded is the lowest index.
  always_comb begin : scan
    lost_any  = 1'b0;
    early_any = 1'b0;
    low_any   = 1'b0;
    high_any  = 1'b0;
    lost_idx  = '0;
    early_idx = '0;
    low_idx   = '0;
    high_idx  = '0;
    for (int j = N_STAGES - 1; j >= 0; j--) begin
      if (!Stage_Confirm[j]) begin
        low_any = 1'b1;
        low_idx = IDX_W'(j);
        if (j < int'(k)) begin
          lost_any = 1'b1;
          lost_idx = IDX_W'(j);
        end
      end else begin
        high_any = 1'b1;
        high_idx = IDX_W'(j);
        if (j > int'(k)) begin
          early_any = 1'b1;
          early_idx = IDX_W'(j);
        end
      end
    end
  end

  always_comb begin : next_state
    state_n  = state;
    k_n      = k;
    cnt_n    = cnt;
    code_n   = Fault_Code;
    fstage_n = Fault_Stage;
    f_hit    = 1'b0;
    f_code   = 2'b00;
    f_idx    = '0;
    case (state)
      S_IDLE: begin
        if (go) begin
          k_n   = '0;
          cnt_n = '0;
          if (high_any) begin
            f_hit  = 1'b1;
            f_code = 2'b10;
            f_idx  = high_idx;
          end else begin
            state_n = S_STEP;
          end
        end
      end
      S_STEP, S_SETTLE: begin
        cnt_n = cnt + CNT_W'(1);
        if (lost_any) begin
          f_hit  = 1'b1;
          f_code = 2'b11;
          f_idx  = lost_idx;
        end else if (early_any) begin
          f_hit  = 1'b1;
          f_code = 2'b10;
          f_idx  = early_idx;
        end else if (state == S_SETTLE && !conf_k) begin
          f_hit  = 1'b1;
          f_code = 2'b11;
          f_idx  = k;
        end else if (!go) begin
          state_n = S_STOP;
          cnt_n   = '0;
        end else if (state == S_STEP) begin
          // A confirm arriving on the timeout cycle still counts.
          if (conf_k) begin
            state_n = S_SETTLE;
            cnt_n   = '0;
          end else if (cnt == TO_LAST) begin
            f_hit  = 1'b1;
            f_code = 2'b01;
            f_idx  = k;
          end
        end else if (cnt == ST_LAST) begin
          cnt_n = '0;
          if (k == K_LAST) begin
            state_n = S_RUN;
          end else begin
            state_n = S_STEP;
            k_n     = k + IDX_W'(1);
          end
        end
      end
      S_RUN: begin
        if (low_any) begin
          f_hit  = 1'b1;
          f_code = 2'b11;
          f_idx  = low_idx;
        end else if (!go) begin
          state_n = S_STOP;
          k_n     = K_LAST;
          cnt_n   = '0;
        end
      end
      S_STOP: begin
        if (cnt == ST_LAST) begin
          cnt_n = '0;
          if (k == '0) state_n = S_IDLE;
          else         k_n     = k - IDX_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_FAULT: begin
        if (Fault_Clear && !Start_Request) begin
          state_n  = S_IDLE;
          k_n      = '0;
          cnt_n    = '0;
          code_n   = 2'b00;
          fstage_n = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (f_hit) begin
      state_n  = S_FAULT;
      cnt_n    = '0;
      code_n   = f_code;
      fstage_n = f_idx;
    end
  end

  // Outputs decoded from the next state so they register with it.
  always_comb begin : decode
    en_n    = '0;
    ms_n    = 1'b0;
    busy_n  = 1'b0;
    fault_n = 1'b0;
    case (state_n)
      S_STEP, S_SETTLE: begin
        busy_n = 1'b1;
        for (int j = 0; j < N_STAGES; j++) en_n[j] = (j <= int'(k_n));
      end
      S_RUN: begin
        en_n = '1;
        ms_n = 1'b1;
      end
      S_STOP: begin
        busy_n = 1'b1;
        for (int j = 0; j < N_STAGES; j++) en_n[j] = (j < int'(k_n));
      end
      S_FAULT: fault_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge System_Clock or posedge System_Reset) begin
    if (System_Reset) begin
      state         <= S_IDLE;
      k             <= '0;
      cnt           <= '0;
      Stage_Enable  <= '0;
      Master_Start  <= 1'b0;
      Sequence_Busy <= 1'b0;
      Fault         <= 1'b0;
      Fault_Stage   <= '0;
      Fault_Code    <= 2'b00;
    end else begin
      state         <= state_n;
      k             <= k_n;
      cnt           <= cnt_n;
      Stage_Enable  <= en_n;
      Master_Start  <= ms_n;
      Sequence_Busy <= busy_n;
      Fault         <= fault_n;
      Fault_Stage   <= fstage_n;
      Fault_Code    <= code_n;
    end
  end

endmodule

// File: tb/tb_safe_startup_sequencer.sv
// tb/tb_safe_startup_sequencer.sv - directed and randomized check of safe_startup_sequencer against a timestamp model
module tb_safe_startup_sequencer;
  localparam int N = 4, T = 1000, S = 16, IDX_W = 2, BIG = 5000;
  localparam int M_IDLE = 0, M_STEP = 1, M_SETTLE = 2, M_RUN = 3, M_STOP = 4, M_FAULT = 5;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, clr = 1'b0;
  logic [N-1:0] conf = '0;
  logic [N-1:0] en;
  logic ms, busy, flt;
  logic [IDX_W-1:0] fstage;
  logic [1:0] fcode;

  safe_startup_sequencer #(.N_STAGES(N), .TIMEOUT_CYCLES(T), .SETTLE_CYCLES(S)) dut (
    .System_Clock(clk), .System_Reset(rst), .Start_Request(start), .Stop_Request(stop),
    .Stage_Confirm(conf), .Fault_Clear(clr), .Stage_Enable(en), .Master_Start(ms),
    .Sequence_Busy(busy), .Fault(flt), .Fault_Stage(fstage), .Fault_Code(fcode));

  always #5 clk = ~clk;

  // Model: mode plus the edge number at which it was entered; timing from differences.
  int m_mode, m_k, m_t0, now, m_code, m_stage;
  logic [N-1:0] exp_en;
  logic exp_ms, exp_busy, exp_fault;
  logic [IDX_W-1:0] exp_stage;
  logic [1:0] exp_code;

  int total = 0, bad = 0, cyc = 0;
  int age[N], dly[N];
  logic [N-1:0] force_hi = '0, force_lo = '0;
  bit rand_dly = 0;

  function automatic int lowest(input logic [N-1:0] v);
    for (int j = 0; j < N; j++) if (v[j]) return j;
    return -1;
  endfunction

  function automatic logic [N-1:0] below(input int n);
    logic [N-1:0] m;
    m = '0;
    for (int j = 0; j < N; j++) if (j < n) m[j] = 1'b1;
    return m;
  endfunction

  task automatic model_outputs();
    exp_en = '0; exp_ms = 0; exp_busy = 0; exp_fault = 0;
    case (m_mode)
      M_STEP, M_SETTLE: begin exp_en = below(m_k + 1); exp_busy = 1; end
      M_RUN:            begin exp_en = '1; exp_ms = 1; end
      M_STOP:           begin exp_en = below(m_k - (now - m_t0) / S); exp_busy = 1; end
      M_FAULT:          exp_fault = 1;
      default: ;
    endcase
    exp_stage = IDX_W'(m_stage);
    exp_code  = 2'(m_code);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_k = 0; m_t0 = 0; now = 0; m_code = 0; m_stage = 0;
    model_outputs();
  endtask

  task automatic model_step();
    int lost, early, f_code, f_idx;
    bit go;
    if (rst) begin
      model_reset();
      return;
    end
    now++;
    go = start && !stop;
    f_code = 0; f_idx = 0;
    lost  = lowest(~conf & below(m_k));
    early = lowest(conf & ~below(m_k + 1));
    case (m_mode)
      M_IDLE: if (go) begin
        if (conf != '0) begin f_code = 2; f_idx = lowest(conf); end
        else begin m_mode = M_STEP; m_k = 0; m_t0 = now; end
      end
      M_STEP, M_SETTLE: begin
        if (lost >= 0) begin f_code = 3; f_idx = lost; end
        else if (early >= 0) begin f_code = 2; f_idx = early; end
        else if (m_mode == M_SETTLE && !conf[m_k]) begin f_code = 3; f_idx = m_k; end
        else if (!go) begin m_mode = M_STOP; m_t0 = now; end
        else if (m_mode == M_STEP) begin
          if (conf[m_k]) begin m_mode = M_SETTLE; m_t0 = now; end
          else if (now - m_t0 == T) begin f_code = 1; f_idx = m_k; end
        end else if (now - m_t0 == S) begin
          if (m_k == N - 1) m_mode = M_RUN;
          else begin m_k++; m_mode = M_STEP; m_t0 = now; end
        end
      end
      M_RUN: begin
        if (conf != '1) begin f_code = 3; f_idx = lowest(~conf); end
        else if (!go) begin m_mode = M_STOP; m_k = N - 1; m_t0 = now; end
      end
      M_STOP: if (m_k - (now - m_t0) / S < 0) begin m_mode = M_IDLE; m_k = 0; end
      M_FAULT: if (clr && !start) begin m_mode = M_IDLE; m_k = 0; m_code = 0; m_stage = 0; end
      default: ;
    endcase
    if (f_code != 0) begin m_mode = M_FAULT; m_code = f_code; m_stage = f_idx; end
    model_outputs();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_cycle();
    logic [N+IDX_W+4:0] act, exp;
    act = {en, ms, busy, flt, fstage, fcode};
    exp = {exp_en, exp_ms, exp_busy, exp_fault, exp_stage, exp_code};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cycle %0d outputs: dut=%h model=%h", cyc, act, exp);
    end
  endtask

  // Plant: confirm[j] follows its enable after dly[j] cycles, with one-shot overrides.
  task automatic age_update();
    for (int j = 0; j < N; j++) begin
      if (exp_en[j]) age[j]++;
      else begin
        age[j] = 0;
        if (rand_dly) dly[j] = int'($urandom_range(0, 6));
      end
    end
  endtask

  task automatic drive_conf();
    logic [N-1:0] base;
    base = '0;
    for (int j = 0; j < N; j++) if (exp_en[j] && age[j] > dly[j]) base[j] = 1'b1;
    conf = (base | force_hi) & ~force_lo;
  endtask

  task automatic tick();
    @(negedge clk);
    chk_cycle();
    @(posedge clk);
    model_step();
    #2;
    cyc++;
    age_update();
    drive_conf();
  endtask

  function automatic int cur(input int sel);
    case (sel)
      0: return int'(en);
      1: return int'(ms);
      2: return int'(flt);
      default: return int'(busy);
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int val, input int budget, input string name, output int n);
    n = 0;
    while (cur(sel) != val && n < budget) begin
      tick();
      n++;
    end
    chk(name, cur(sel), val);
  endtask

  initial begin
    int n;
    for (int j = 0; j < N; j++) begin age[j] = 0; dly[j] = 3; end
    model_reset();
    repeat (3) tick();
    chk("reset_outputs", int'({en, ms, busy, flt, fstage, fcode}), 0);
    rst = 0;

    start = 1;
    wait_sig(1, 1, 200, "run_d3", n);
    chk("latency_d3", n - 1, 80);
    chk("run_enables", int'(en), 15);
    chk("run_nofault", int'(flt), 0);

    stop = 1; tick(); stop = 0;
    chk("stop_ms", int'(ms), 0);
    chk("stop_en0", int'(en), 7);
    repeat (16) tick(); chk("stop_en1", int'(en), 3);
    repeat (16) tick(); chk("stop_en2", int'(en), 1);
    repeat (16) tick(); chk("stop_en3", int'(en), 0);
    chk("stop_busy3", int'(busy), 1);
    repeat (16) tick(); chk("stop_idle", int'(busy), 0);
    start = 0; tick();

    dly[0] = 0; dly[1] = BIG;
    start = 1;
    wait_sig(0, 3, 100, "reach_step1", n);
    wait_sig(2, 1, 1100, "timeout_fault", n);
    chk("timeout_latency", n, 1000);
    chk("timeout_code", int'(fcode), 1);
    chk("timeout_stage", int'(fstage), 1);
    chk("timeout_en", int'(en), 0);
    start = 0; clr = 1; tick(); clr = 0;
    chk("timeout_cleared", int'(flt), 0);

    dly[0] = BIG; dly[1] = 3;
    start = 1; tick(); tick();
    force_hi = 4'b0100; drive_conf(); tick(); force_hi = '0; drive_conf();
    chk("early_fault", int'(flt), 1);
    chk("early_code", int'(fcode), 2);
    chk("early_stage", int'(fstage), 2);
    start = 0; clr = 1; tick(); clr = 0;

    force_hi = 4'b1000; drive_conf(); tick();
    chk("idle_conf_nofault", int'(flt), 0);
    start = 1; tick();
    chk("preset_code", int'(fcode), 2);
    chk("preset_stage", int'(fstage), 3);
    force_hi = '0; drive_conf();
    start = 0; clr = 1; tick(); clr = 0;

    for (int j = 0; j < N; j++) dly[j] = 0;
    start = 1;
    wait_sig(1, 1, 200, "run_d0", n);
    chk("latency_d0", n - 1, 68);
    force_lo = 4'b0001; drive_conf(); tick(); force_lo = '0; drive_conf();
    chk("lost_fault", int'(flt), 1);
    chk("lost_ms", int'(ms), 0);
    chk("lost_code", int'(fcode), 3);
    chk("lost_stage", int'(fstage), 0);
    clr = 1; repeat (3) tick();
    chk("clr_ignored", int'(flt), 1);
    chk("clr_ignored_code", int'(fcode), 3);
    start = 0; tick(); clr = 0;
    chk("cleared_outputs", int'({en, ms, busy, flt, fstage, fcode}), 0);

    for (int j = 0; j < N; j++) dly[j] = 3;
    start = 1;
    wait_sig(0, 7, 200, "reach_step2", n);
    repeat (6) tick();
    rst = 1; model_reset(); #1;
    chk("rst_settle", int'({en, ms, busy, flt, fstage, fcode}), 0);
    tick(); rst = 0;
    tick();
    chk("restart_en", int'(en), 1);
    force_hi = 4'b1000; drive_conf(); tick(); force_hi = '0; drive_conf();
    chk("fault_before_rst", int'(flt), 1);
    rst = 1; model_reset(); #1;
    chk("rst_fault", int'({en, ms, busy, flt, fstage, fcode}), 0);
    start = 0; tick(); rst = 0;

    rand_dly = 1; start = 1;
    for (int i = 0; i < 6000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 6) start = ~start;
      stop = (r >= 6 && r < 9);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) force_lo[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 299) == 0) force_hi[$urandom_range(0, N - 1)] = 1'b1;
      drive_conf();
      tick();
      force_hi = '0; force_lo = '0;
      drive_conf();
    end
    stop = 0; clr = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
